// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Memory-mapped interrupt controller for the 8-bit CPU core.
//
// Collects up to CHANNELS maskable interrupt lines plus one NMI line. Each
// channel has a mask bit, an edge/level mode bit, a pending bit and an
// in-service (ISR) bit. Priority is fixed (channel 0 highest) and nesting is
// allowed: a pending request only interrupts the core if it outranks every
// channel already in service.
//
// Register map (relative to BASE):
//   +0 PEND  read pending, write 1 to clear edge-mode bits
//   +1 MASK  read/write, 1 = masked
//   +2 MODE  read/write, 1 = edge, 0 = level
//   +3 STAT  read-only {nmi, irq, isr_active, 2'b0, index[2:0]}
//   +4 EOI   write clears highest-priority ISR bit, read returns ISR
//
// Ports:
//   clock     system clock
//   reset_n   asynchronous active-low reset
//   ce        clock enable shared with the core; gates bus accesses and acks
//   address   core bus address
//   wdata     core write data
//   rd, we    core read / write strobes
//   rdata     registered read data
//   irq_line  asynchronous interrupt inputs, active high
//   nmi_line  asynchronous NMI input, rising-edge triggered
//   irq, nmi  requests to the core
//   irq_ack   core takes the IRQ
//   nmi_ack   core takes the NMI
//   vec       vector latched at the last accepted acknowledge
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int          CHANNELS = 8,
    parameter logic [15:0] BASE     = 16'hFF00,
    parameter logic [15:0] VEC_BASE = 16'hFFE0,
    parameter logic [15:0] NMI_VEC  = 16'hFFFA
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [15:0]         address,
    input  logic [7:0]          wdata,
    input  logic                rd,
    input  logic                we,
    output logic [7:0]          rdata,
    input  logic [CHANNELS-1:0] irq_line,
    input  logic                nmi_line,
    output logic                irq,
    output logic                nmi,
    input  logic                irq_ack,
    input  logic                nmi_ack,
    output logic [15:0]         vec
);

    localparam int CW = CHANNELS;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_MODE = 3'd2;
    localparam logic [2:0] OFF_STAT = 3'd3;
    localparam logic [2:0] OFF_EOI  = 3'd4;

    // Synchroniser and edge-detect history
    logic [CW-1:0] line_s1, line_s2, line_d3;
    logic          nmi_s1, nmi_s2, nmi_d3;

    // Architectural state
    logic [CW-1:0] mask_q, mode_q, pend_edge_q, isr_q;
    logic          nmi_q;
    logic [15:0]   vec_q;
    logic [7:0]    rdata_q;

    // Next-state values
    logic [CW-1:0] mask_n, mode_n, pend_edge_n, isr_n;
    logic          nmi_n;
    logic [15:0]   vec_n;
    logic [7:0]    rdata_n;

    // Decode and priority signals
    logic [CW-1:0] pend, req, req_lowest, line_rise, wd;
    logic [2:0]    p_idx, s_idx;
    logic          irq_c, nmi_rise;
    logic [15:0]   offset;
    logic [2:0]    off;
    logic          sel, wr, rdv, irq_take, nmi_take;

    // The synchronisers and the one-clock history run on every clock,
    // independent of ce, so that no input edge is lost while the core stalls.
    // line_d3 doubles as the level-mode pending source, which gives level and
    // edge channels the same three-clock input latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_s1 <= '0;
            line_s2 <= '0;
            line_d3 <= '0;
            nmi_s1  <= 1'b0;
            nmi_s2  <= 1'b0;
            nmi_d3  <= 1'b0;
        end else begin
            line_s1 <= irq_line;
            line_s2 <= line_s1;
            line_d3 <= line_s2;
            nmi_s1  <= nmi_line;
            nmi_s2  <= nmi_s1;
            nmi_d3  <= nmi_s2;
        end
    end

    // Pending view, request vector and the two priority encoders. Only edge
    // channels hold a latched pending bit; level channels show the live line.
    always_comb begin
        line_rise  = line_s2 & ~line_d3;
        nmi_rise   = nmi_s2 & ~nmi_d3;
        pend       = (pend_edge_q & mode_q) | (line_d3 & ~mode_q);
        req        = pend & ~mask_q;
        // Isolates the lowest set bit, i.e. the winning channel as a one-hot
        req_lowest = req & ((~req) + CW'(1));
        p_idx      = 3'd7;
        s_idx      = 3'd7;
        for (int i = CW - 1; i >= 0; i--) begin
            if (req[i]) begin
                p_idx = 3'(i);
            end
            if (isr_q[i]) begin
                s_idx = 3'(i);
            end
        end
        irq_c = (|req) && ((isr_q == '0) || (p_idx < s_idx));
    end

    // Bus decode and acknowledge qualification. An accepted NMI ack blocks an
    // IRQ ack in the same cycle so the IRQ stays pending for the core.
    always_comb begin
        offset   = address - BASE;
        off      = offset[2:0];
        sel      = (address >= BASE) && (offset < 16'd5);
        wr       = ce && we && sel;
        rdv      = ce && rd && sel;
        wd       = wdata[CW-1:0];
        nmi_take = ce && nmi_ack && nmi_q;
        irq_take = ce && irq_ack && irq_c && !nmi_take;
    end

    // Next-state logic. Ordering inside this block encodes the collision
    // rules: the EOI clear happens before the ack sets its ISR bit, and an
    // incoming edge is applied after any write-clear or ack-clear so set wins.
    always_comb begin
        mask_n      = mask_q;
        mode_n      = mode_q;
        pend_edge_n = pend_edge_q;
        isr_n       = isr_q;
        nmi_n       = nmi_q;
        vec_n       = vec_q;
        rdata_n     = rdata_q;

        if (wr && off == OFF_MASK) begin
            mask_n = wd;
        end
        if (wr && off == OFF_MODE) begin
            mode_n = wd;
        end
        if (wr && off == OFF_PEND) begin
            pend_edge_n = pend_edge_n & ~wd;
        end
        if (wr && off == OFF_EOI) begin
            // Clears the lowest set bit, which is the highest-priority one
            isr_n = isr_q & (isr_q - CW'(1));
        end

        if (irq_take) begin
            pend_edge_n = pend_edge_n & ~req_lowest;
            isr_n       = isr_n | req_lowest;
            vec_n       = VEC_BASE + {12'd0, p_idx, 1'b0};
        end
        if (nmi_take) begin
            nmi_n = 1'b0;
            vec_n = NMI_VEC;
        end
        if (nmi_rise) begin
            nmi_n = 1'b1;
        end

        pend_edge_n = pend_edge_n | (line_rise & mode_q);
        // A channel now in level mode keeps no latched edge
        pend_edge_n = pend_edge_n & mode_n;

        if (rdv) begin
            rdata_n = '0;
            case (off)
                OFF_PEND: rdata_n[CW-1:0] = pend;
                OFF_MASK: rdata_n[CW-1:0] = mask_q;
                OFF_MODE: rdata_n[CW-1:0] = mode_q;
                OFF_STAT: rdata_n = {nmi_q, irq_c, |isr_q, 2'b00, p_idx};
                default:  rdata_n[CW-1:0] = isr_q;
            endcase
        end
    end

    // Architectural state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= '1;
            mode_q      <= '1;
            pend_edge_q <= '0;
            isr_q       <= '0;
            nmi_q       <= 1'b0;
            vec_q       <= VEC_BASE;
            rdata_q     <= 8'h00;
        end else begin
            mask_q      <= mask_n;
            mode_q      <= mode_n;
            pend_edge_q <= pend_edge_n;
            isr_q       <= isr_n;
            nmi_q       <= nmi_n;
            vec_q       <= vec_n;
            rdata_q     <= rdata_n;
        end
    end

    assign irq   = irq_c;
    assign nmi   = nmi_q;
    assign vec   = vec_q;
    assign rdata = rdata_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised, memory-mapped interrupt controller for the 8-bit CPU core.
- Gathers up to CHANNELS external interrupt lines plus one NMI line, and tracks each with per-channel mask, edge/level mode, pending and in-service state.
- Fixed priority with nesting: channel 0 is the highest priority.
- Raises irq/nmi requests to the core, returns a 16-bit vector on acknowledge, and is accessed over the core's bus (address/in/out/rd/we with ce).

Parameters:
CHANNELS, 8, number of interrupt lines (1..8); unused register bits read 0
BASE, 16'hFF00, bus address of register 0; registers occupy BASE..BASE+4
VEC_BASE, 16'hFFE0, vector for channel k = VEC_BASE + 2*k
NMI_VEC, 16'hFFFA, vector returned on NMI acknowledge

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  clock enable shared with core; gates bus accesses and acks
address  in  16  core bus address
wdata  in  8  core write data (core "out")
rd  in  1  core read strobe
we  in  1  core write strobe
rdata  out  8  register read data
irq_line  in  CHANNELS  asynchronous interrupt inputs, active high
nmi_line  in  1  asynchronous NMI input, rising-edge triggered
irq  out  1  maskable request to core
nmi  out  1  NMI request to core
irq_ack  in  1  core takes IRQ (one ce cycle)
nmi_ack  in  1  core takes NMI (one ce cycle)
vec  out  16  vector latched at last ack

Behaviour:
Reset and synchronisation:
- Reset is asynchronous: rdata=0, irq=0, nmi=0, vec=VEC_BASE. MASK=all 1 (all masked), MODE=all 1 (edge), PEND=0, ISR=0, synchroniser flops=0.
- irq_line and nmi_line each pass through a 2-flop synchroniser that runs every clock, not gated by ce.
- Edge detect compares the synchronised value with the previous clock's value, so no edge is lost while ce=0. Input-to-pending latency is 3 clocks.

Register map (sel = address in BASE..BASE+4):
- +0 PEND: read gives pending bits. Write 1 to clear edge-mode bits. For level-mode channels the pending bit is the live synchronised line, and writes have no effect.
- +1 MASK: read/write; 1 = masked.
- +2 MODE: read/write; 1 = edge, 0 = level. Switching a channel edge->level discards its latched pending bit.
- +3 STAT: read-only {nmi, irq, ISR-active, 2'b0, index[2:0]}. index = highest-priority unmasked pending channel, 7 if none.
- +4 EOI: write of any value clears the highest-priority set ISR bit. Reads give ISR.

Bus timing:
- Writes take effect on a clock with ce && we && sel.
- Reads: on a clock with ce && rd && sel, rdata is registered and valid from the next clock. It holds until the next read; unselected reads leave rdata unchanged.

IRQ priority and acknowledge:
- req = PEND & ~MASK; p = lowest set index of req; s = lowest set index of ISR (none if ISR=0).
- irq = 1 when req != 0 and (ISR == 0 or p < s). This is combinational from registered state.
- On ce && irq_ack with irq=1:
  - ISR[p] set; if channel p is edge mode, PEND[p] cleared.
  - vec = VEC_BASE + 2*p, registered.
  - irq falls the next clock unless a higher-priority channel is pending.
- irq_ack while irq=0 is ignored; vec and ISR are unchanged.

NMI:
- A synchronised rising edge of nmi_line sets nmi. nmi holds until ce && nmi_ack, which clears nmi and loads vec = NMI_VEC.
- The NMI path is independent of MASK and ISR.
- nmi_ack takes precedence over an irq_ack in the same cycle; the irq_ack is ignored and irq stays asserted.

Simultaneous events:
- An edge arriving on the same clock as a PEND write-clear of that bit: set wins.
- An edge on the same clock as an ack: the ack uses p computed from pre-update state, and the new edge sets its pending bit.
- EOI with ISR=0: no effect.
- EOI on the same clock as an ack: the ack's ISR set is applied after the EOI clear.
- Reset asserted mid-operation (any state) returns everything to the reset values immediately.

Test Plan:
- Reset, MASK=8'hFF after reset: pulse irq_line[3] -> PEND=8'h08 three clocks later, irq stays 0. Write MASK=8'hF7 -> irq=1; STAT index reads 3.
- Unmasked channel 3 pending, irq_ack -> vec=VEC_BASE+6=16'hFFE6, ISR=8'h08, PEND=0, irq=0. Write EOI -> ISR=0.
- Nesting: with ISR[3] set, edge on ch5 -> irq stays 0. Edge on ch1 -> irq=1; ack -> vec=16'hFFE2, ISR=8'h0A. EOI clears bit1; second EOI clears bit3; irq then asserts for ch5.
- Level mode: MODE=8'h00, MASK=8'h00, irq_line[0] held high -> irq=1. Writing PEND=8'h01 does not clear it. Dropping the line clears PEND[0] three clocks later.
- NMI: rising edge on nmi_line, with nmi_ack and irq_ack asserted together in the same ce cycle -> vec=16'hFFFA, nmi=0, irq still 1, ISR unchanged.
- Asynchronous reset asserted mid-ack sequence with ce=0 -> all outputs return to reset values without a clock edge. Edge/write-clear collision on the same clock -> PEND bit remains 1.
